// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display path: segment codes, digit states,
// and the BCD-valid predicate.
package bcd_pkg;

  // Active-low gfedcba segment codes
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    UNITS = 2'd0,
    TENS  = 2'd1,
    HUND  = 2'd2
  } digit_t;

  function automatic logic bcd_valid(input logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to active-low 7-segment decoder; non-BCD values show E.
module bcd_to_seg
  import bcd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    unique case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Captures a 2-digit BCD sum plus carry and drives a 3-digit multiplexed
// common-anode display. Optional leading-zero blanking: BCD_DISP_LZB_EN.
module bcd_display_mux
  import bcd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] sum,
  input  logic       cout,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       err
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [8:0]    cap;
  logic [CW-1:0] cnt;
  logic          tc;
  digit_t        state, state_nxt;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_nxt;
  logic [2:0]    an_nxt;
  logic          blank;

  assign tc  = (cnt == CW'(REFRESH_DIV - 1));
  assign err = ~bcd_valid(cap[3:0]) | ~bcd_valid(cap[7:4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap   <= '0;
      cnt   <= '0;
      state <= UNITS;
    end else begin
      if (load)
        cap <= {cout, sum};
      cnt   <= tc ? '0 : cnt + CW'(1);
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tc) begin
      unique case (state)
        UNITS:   state_nxt = TENS;
        TENS:    state_nxt = HUND;
        default: state_nxt = UNITS;
      endcase
    end
  end

  // Digit select and enables from the current state; unreachable encoding maps to units
  always_comb begin
    nib    = cap[3:0];
    an_nxt = 3'b110;
    blank  = 1'b0;
    unique case (state)
      TENS: begin
        nib    = cap[7:4];
        an_nxt = 3'b101;
`ifdef BCD_DISP_LZB_EN
        blank  = ~cap[8] & (cap[7:4] == 4'd0);
`endif
      end
      HUND: begin
        nib    = {3'b000, cap[8]};
        an_nxt = 3'b011;
`ifdef BCD_DISP_LZB_EN
        blank  = ~cap[8];
`endif
      end
      default: begin
        nib    = cap[3:0];
        an_nxt = 3'b110;
      end
    endcase
  end

  bcd_to_seg u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Blanking only ever fires for a zero nibble, so E is never suppressed
  assign seg_nxt = blank ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized self-checking bench for bcd_display_mux with REFRESH_DIV=4;
// honours BCD_DISP_LZB_EN in the reference model.
module tb_bcd_display_mux;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] sum = '0;
  logic       cout = 1'b0;
  logic [2:0] an;
  logic [6:0] seg;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: captured value and edges since reset release
  logic [8:0] m_cap = '0;
  int         m_cyc = 0;

  localparam logic [6:0] SEGTAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_display_mux #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .sum  (sum),
    .cout (cout),
    .an   (an),
    .seg  (seg),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] ref_seg(input int idx, input logic [8:0] c);
    int v;
    int tens, hund;
    tens = int'(c[7:4]);
    hund = int'(c[8]);
    v = (idx == 0) ? int'(c[3:0]) : (idx == 1) ? tens : hund;
    if (v > 9) return 7'h06;
`ifdef BCD_DISP_LZB_EN
    if (idx == 2 && hund == 0) return 7'h7F;
    if (idx == 1 && hund == 0 && tens == 0) return 7'h7F;
`endif
    return SEGTAB[v];
  endfunction

  // One clock: drive inputs, predict registered outputs, check at negedge
  task automatic step(input logic l, input logic [7:0] s, input logic c);
    int idx;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_err;
    load = l; sum = s; cout = c;
    idx     = (m_cyc / DIV) % 3;
    exp_an  = 3'b111 & ~(3'b001 << idx);
    exp_seg = ref_seg(idx, m_cap);
    if (l) m_cap = {c, s};
    m_cyc++;
    exp_err = (m_cap[3:0] > 4'd9) || (m_cap[7:4] > 4'd9);
    @(posedge clk);
    @(negedge clk);
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("err", 32'(err), 32'(exp_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'h7);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_err", 32'(err), 32'h0);
    m_cap = '0;
    m_cyc = 0;
    load  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_until_phase(input int phase);
    for (int i = 0; i < 3 * DIV && (m_cyc % (3 * DIV)) != phase; i++)
      step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3 * DIV + 2; i++) step(1'b0, 8'h00, 1'b0);

    idle_until_phase(0);
    step(1'b1, 8'h57, 1'b1);
    for (int i = 0; i < 3 * DIV; i++) step(1'b0, 8'h00, 1'b0);

    step(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 3 * DIV; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    step(1'b1, 8'h05, 1'b0);
    for (int i = 0; i < 3 * DIV; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < 3 * DIV; i++) step(1'b0, 8'h00, 1'b0);

    // Load on the units->tens terminal count edge
    idle_until_phase(DIV - 1);
    step(1'b1, 8'h42, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Reset mid-slot while showing 99
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    do_reset();
    for (int i = 0; i < DIV; i++) step(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 500; i++) begin
      logic [7:0] s;
      s = 8'($urandom);
      if ($urandom_range(0, 2) != 0)
        s = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 7) == 0)
        s = {4'h0, s[3:0]};
      if ($urandom_range(0, 149) == 0)
        do_reset();
      else
        step($urandom_range(0, 3) == 0, s, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
